// File: rtl/sda_rx.sv
// Two-wire bus receiver: synchronises SCL/SDA, flags START/STOP, deserialises MSB-first words and captures the ACK slot.
// Latency: pulses appear 3 clk edges after a pad change; no backpressure, pulses are fire-and-forget.
module sda_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  byte_received,
    output logic                  rx_ack,
    output logic                  ack_valid,
    output logic                  start_found,
    output logic                  stop_found,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Synchroniser chain: m = metastable stage, s = synchronised, p = previous s.
    logic scl_m_q, scl_s_q, scl_p_q;
    logic sda_m_q, sda_s_q, sda_p_q;
    logic scl_m_d, scl_s_d, scl_p_d;
    logic sda_m_d, sda_s_d, sda_p_d;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    // Only DATA_WIDTH-1 bits are kept: the oldest bit would be shifted out
    // before the word completes, so it is never observable.
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shift_word;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_ack_q, rx_ack_d;
    logic                  byte_received_q, byte_received_d;
    logic                  ack_valid_q, ack_valid_d;
    logic                  start_found_q, start_found_d;
    logic                  stop_found_q, stop_found_d;

    logic scl_rise;
    logic start_cond;
    logic stop_cond;

    always_comb begin
        scl_m_d = scl_in;
        scl_s_d = scl_m_q;
        scl_p_d = scl_s_q;
        sda_m_d = sda_in;
        sda_s_d = sda_m_q;
        sda_p_d = sda_s_q;
    end

    assign scl_rise   = !scl_p_q && scl_s_q;
    assign start_cond = scl_p_q && scl_s_q && sda_p_q && !sda_s_q;
    assign stop_cond  = scl_p_q && scl_s_q && !sda_p_q && sda_s_q;

    assign shift_word = {shift_q, sda_s_q};

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        rx_data_d       = rx_data_q;
        rx_ack_d        = rx_ack_q;
        byte_received_d = 1'b0;
        ack_valid_d     = 1'b0;
        start_found_d   = 1'b0;
        stop_found_d    = 1'b0;

        if (stop_cond) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            stop_found_d = 1'b1;
        end else if (start_cond) begin
            // Covers both a fresh START and a repeated START mid-transfer.
            state_d       = ST_RECV;
            bit_cnt_d     = '0;
            shift_d       = '0;
            start_found_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RECV: begin
                    if (scl_rise) begin
                        shift_d = shift_word[DATA_WIDTH-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d       = shift_word;
                            byte_received_d = 1'b1;
                            bit_cnt_d       = '0;
                            state_d         = ST_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_ACK: begin
                    if (scl_rise) begin
                        rx_ack_d    = sda_s_q;
                        ack_valid_d = 1'b1;
                        state_d     = ST_RECV;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_m_q <= 1'b1;
            scl_s_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_m_q <= 1'b1;
            sda_s_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_m_q <= scl_m_d;
            scl_s_q <= scl_s_d;
            scl_p_q <= scl_p_d;
            sda_m_q <= sda_m_d;
            sda_s_q <= sda_s_d;
            sda_p_q <= sda_p_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            rx_data_q       <= '0;
            rx_ack_q        <= 1'b1;
            byte_received_q <= 1'b0;
            ack_valid_q     <= 1'b0;
            start_found_q   <= 1'b0;
            stop_found_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            rx_data_q       <= rx_data_d;
            rx_ack_q        <= rx_ack_d;
            byte_received_q <= byte_received_d;
            ack_valid_q     <= ack_valid_d;
            start_found_q   <= start_found_d;
            stop_found_q    <= stop_found_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_ack        = rx_ack_q;
    assign byte_received = byte_received_q;
    assign ack_valid     = ack_valid_q;
    assign start_found   = start_found_q;
    assign stop_found    = stop_found_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
